// File: rtl/counter_cmd_driver_if.sv
// Request port plus counter command / read-back bundle for counter_cmd_driver.
// master = the driver, slave = requester and counter side.
interface counter_cmd_driver_if #(
    parameter int WIDTH = 5
) ();
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_target;
    logic             req_mode;
    logic [WIDTH-1:0] count_in;
    logic             flag_high;
    logic             flag_low;
    logic             load;
    logic             up;
    logic             down;
    logic [WIDTH-1:0] in;
    logic             done;
    logic             err;

    modport master (
        input  req_valid, req_target, req_mode, count_in, flag_high, flag_low,
        output req_ready, load, up, down, in, done, err
    );

    modport slave (
        output req_valid, req_target, req_mode, count_in, flag_high, flag_low,
        input  req_ready, load, up, down, in, done, err
    );
endinterface

// File: rtl/counter_cmd_driver.sv
// Drives LOAD/UP/DOWN/IN of an up/down counter until its read-back equals a requested target.
// Optional watchdog: define CNT_DRV_TIMEOUT_EN to force ERR after TIMEOUT_CYC busy cycles.
module counter_cmd_driver #(
    parameter int WIDTH       = 5,
    parameter int TIMEOUT_CYC = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_cmd_driver_if.master bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_JUMP    = 3'd1;
    localparam logic [2:0] S_STEP_UP = 3'd2;
    localparam logic [2:0] S_STEP_DN = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_CMP     = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [2:0] S_ERR     = 3'd7;

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("counter_cmd_driver: TIMEOUT_CYC must be at least 2");
    end

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] target_q;
    logic             mode_q;
    logic             accept;
    logic             timeout_hit;

    logic             ready_q, load_q, up_q, down_q, done_q, err_q;
    logic [WIDTH-1:0] in_q;

    assign accept = bus.req_valid && ready_q;

`ifdef CNT_DRV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] timer_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            timer_q <= '0;
        end else if (accept) begin
            timer_q <= '0;
        end else if (state_q != S_IDLE) begin
            timer_q <= timer_q + 1'b1;
        end
    end

    // Fires on the edge where the timer would step onto TIMEOUT_CYC; the pulse states are exempt.
    assign timeout_hit = (timer_q == TW'(TIMEOUT_CYC - 1)) &&
                         (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        if (timeout_hit) begin
            state_d = S_ERR;
        end else begin
            case (state_q)
                S_IDLE:    if (accept) state_d = bus.req_mode ? S_JUMP : S_CMP;
                S_JUMP,
                S_STEP_UP,
                S_STEP_DN: state_d = S_WAIT;
                S_WAIT:    state_d = S_CMP;
                S_CMP: begin
                    if (bus.count_in == target_q)     state_d = S_DONE;
                    else if (mode_q)                  state_d = S_ERR;
                    else if (bus.count_in < target_q) state_d = bus.flag_high ? S_ERR : S_STEP_UP;
                    else                              state_d = bus.flag_low  ? S_ERR : S_STEP_DN;
                end
                S_DONE,
                S_ERR:     state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they change with the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            mode_q   <= 1'b0;
            ready_q  <= 1'b0;
            load_q   <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            in_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of the others.
            state_q <= state_d;
            if (accept) begin
                target_q <= bus.req_target;
                mode_q   <= bus.req_mode;
            end
            ready_q <= (state_d == S_IDLE);
            load_q  <= (state_d == S_JUMP);
            up_q    <= (state_d == S_STEP_UP);
            down_q  <= (state_d == S_STEP_DN);
            // JUMP is only entered on the accepting edge, so the live request target is the one to load.
            in_q    <= (state_d == S_JUMP) ? bus.req_target : '0;
            done_q  <= (state_d == S_DONE) || (state_d == S_ERR);
            err_q   <= (state_d == S_ERR);
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.load      = load_q;
    assign bus.up        = up_q;
    assign bus.down      = down_q;
    assign bus.in        = in_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_counter_cmd_driver.sv
// Scoreboard bench for counter_cmd_driver against a registered, saturating 5-bit counter model.
// Cycle k of a request is the interval after the k-th edge counted from the accepting edge (k=1 first).
module tb_counter_cmd_driver;
    localparam int WIDTH = 5;

    typedef enum int {EV_LOAD = 1, EV_UP = 2, EV_DOWN = 3, EV_OK = 4, EV_ERR = 5} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       val;
        int       at;
    } exp_t;

    exp_t sb_q[$];
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   ecnt = 0;

    logic [WIDTH-1:0] cnt = '0;
    logic [WIDTH-1:0] preset_val = '0;
    logic             preset_en = 1'b0;
    logic             stuck = 1'b0;
    logic             force_high = 1'b0;

    ev_kind_t mon_kind;
    exp_t     mon_exp;

    counter_cmd_driver_if #(.WIDTH(WIDTH)) bus ();

    counter_cmd_driver #(.WIDTH(WIDTH), .TIMEOUT_CYC(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    always @(posedge clk) begin
        if (preset_en) cnt <= preset_val;
        else if (!stuck) begin
            if (bus.load)                  cnt <= bus.in;
            else if (bus.up && cnt != 31)  cnt <= cnt + 1'b1;
            else if (bus.down && cnt != 0) cnt <= cnt - 1'b1;
        end
    end

    assign bus.count_in  = cnt;
    assign bus.flag_high = (cnt == 5'd31) || force_high;
    assign bus.flag_low  = (cnt == 5'd0);

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    // Monitor: every strobe or DONE pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.load || bus.up || bus.down || bus.done) begin
            check("one_strobe", $countones({bus.load, bus.up, bus.down, bus.done}), 1);
            if (bus.up)   check("up_at_max", int'(cnt == 5'd31), 0);
            if (bus.down) check("down_at_zero", int'(cnt == 5'd0), 0);
            if (bus.load)      mon_kind = EV_LOAD;
            else if (bus.up)   mon_kind = EV_UP;
            else if (bus.down) mon_kind = EV_DOWN;
            else if (bus.err)  mon_kind = EV_ERR;
            else               mon_kind = EV_OK;
            check("event_expected", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                mon_exp = sb_q.pop_front();
                check("ev_kind", int'(mon_kind), int'(mon_exp.kind));
                check("ev_edge", ecnt, mon_exp.at);
                if (mon_exp.kind == EV_LOAD) check("load_in", int'(bus.in), mon_exp.val);
            end
        end
        if (!bus.load) check("in_zero", int'(bus.in), 0);
    end

    task automatic preset(input int v);
        preset_val = v[WIDTH-1:0];
        preset_en  = 1'b1;
        @(negedge clk);
        preset_en  = 1'b0;
    endtask

    // Leaves valid high at the negedge before the accepting edge; acc is that edge's index.
    task automatic start_req(input int target, input bit mode, output int acc);
        int n = 0;
        bus.req_valid  = 1'b1;
        bus.req_target = target[WIDTH-1:0];
        bus.req_mode   = mode;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_seen", int'(bus.req_ready), 1);
        acc = ecnt + 1;
    endtask

    task automatic expect_ev(input ev_kind_t k, input int v, input int acc, input int cyc);
        sb_q.push_back('{kind: k, val: v, at: acc + cyc - 1});
    endtask

    task automatic release_req();
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic finish_req(input int budget);
        int n = 0;
        bit rdy_seen = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            if (bus.req_ready) rdy_seen = 1;
            @(negedge clk);
            n++;
        end
        check("done_seen", int'(bus.done), 1);
        check("ready_low_busy", int'(rdy_seen), 0);
        #1;
        check("sb_drained", sb_q.size(), 0);
        @(negedge clk);
        check("ready_after_done", int'(bus.req_ready), 1);
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        @(negedge clk);
        check("rst_strobes", int'({bus.load, bus.up, bus.down, bus.done, bus.err}), 0);
        check("rst_ready", int'(bus.req_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_release", int'(bus.req_ready), 1);
        #1;
        check("sb_drained_rst", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bus.req_valid  = 1'b0;
        bus.req_target = '0;
        bus.req_mode   = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_strobes", int'({bus.load, bus.up, bus.down, bus.done, bus.err}), 0);
        check("reset_ready", int'(bus.req_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_first_cycle", int'(bus.req_ready), 1);

        // RAMP 3 -> 6
        preset(3);
        start_req(6, 1'b0, acc);
        expect_ev(EV_UP, 0, acc, 2);
        expect_ev(EV_UP, 0, acc, 5);
        expect_ev(EV_UP, 0, acc, 8);
        expect_ev(EV_OK, 0, acc, 11);
        release_req();
        finish_req(30);
        check("ramp_final_count", int'(cnt), 6);

        // JUMP 3 -> 25
        preset(3);
        start_req(25, 1'b1, acc);
        expect_ev(EV_LOAD, 25, acc, 1);
        expect_ev(EV_OK, 0, acc, 4);
        release_req();
        finish_req(10);
        check("jump_final_count", int'(cnt), 25);

        // RAMP 2 -> 0 and 30 -> 31
        preset(2);
        start_req(0, 1'b0, acc);
        expect_ev(EV_DOWN, 0, acc, 2);
        expect_ev(EV_DOWN, 0, acc, 5);
        expect_ev(EV_OK, 0, acc, 8);
        release_req();
        finish_req(20);
        preset(30);
        start_req(31, 1'b0, acc);
        expect_ev(EV_UP, 0, acc, 2);
        expect_ev(EV_OK, 0, acc, 5);
        release_req();
        finish_req(20);

        // RAMP with N=0 at the max boundary
        start_req(31, 1'b0, acc);
        expect_ev(EV_OK, 0, acc, 2);
        release_req();
        finish_req(10);

        // Inconsistent FLAG_High while below target
        preset(3);
        force_high = 1'b1;
        start_req(6, 1'b0, acc);
        expect_ev(EV_ERR, 0, acc, 2);
        release_req();
        finish_req(10);
        force_high = 1'b0;

        // Counter stuck at 31, RAMP target 10
        preset(31);
        stuck = 1'b1;
        start_req(10, 1'b0, acc);
`ifdef CNT_DRV_TIMEOUT_EN
        for (int c = 2; c <= 20; c += 3) expect_ev(EV_DOWN, 0, acc, c);
        expect_ev(EV_ERR, 0, acc, 21);
        release_req();
        finish_req(40);
`else
        for (int c = 2; c <= 11; c += 3) expect_ev(EV_DOWN, 0, acc, c);
        release_req();
        while (ecnt < acc + 11) @(negedge clk);
        reset_pulse();
`endif

        // JUMP mismatch: stuck counter ignores LOAD
        start_req(5, 1'b1, acc);
        expect_ev(EV_LOAD, 5, acc, 1);
        expect_ev(EV_ERR, 0, acc, 4);
        release_req();
        finish_req(10);
        stuck = 1'b0;

        // Reset during cycle 4 of a RAMP, then a fresh request
        preset(0);
        start_req(9, 1'b0, acc);
        expect_ev(EV_UP, 0, acc, 2);
        release_req();
        while (ecnt < acc + 3) @(negedge clk);
        reset_pulse();
        start_req(17, 1'b1, acc);
        expect_ev(EV_LOAD, 17, acc, 1);
        expect_ev(EV_OK, 0, acc, 4);
        release_req();
        finish_req(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
